// File: rtl/dn_ram_sink.sv
// Download sink: buffers boot-loader bytes, writes them to RAM over req/ack and sequences CPU start.
// Optional DN_SINK_CHECKSUM_EN adds dn_checksum, a mod-2^16 sum of committed bytes.
module dn_ram_sink #(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       MEM_AW     = 21,
    parameter logic [MEM_AW-1:0] BASE_ADDR  = '0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dn_go,
    input  logic              dn_wr,
    input  logic [15:0]       dn_addr,
    input  logic [7:0]        dn_data,
    input  logic [15:0]       execute_addr,
    input  logic              execute_enable,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic [15:0]       cpu_start_addr,
    output logic              dn_overflow,
    output logic [16:0]       byte_count
`ifdef DN_SINK_CHECKSUM_EN
    ,
    output logic [15:0]       dn_checksum
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StLaunch} state_e;

    state_e        state;
    logic          dn_go_q;
    logic          dn_wr_q;
    logic          exec_latched;
    logic [PtrW:0] wr_ptr;
    logic [PtrW:0] rd_ptr;
    logic [15:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];

    logic            fifo_empty;
    logic            fifo_full;
    logic            load_entry;
    logic            accept;
    logic            ack_hit;
    logic            push;
    logic            issue;
    logic [PtrW-1:0] rd_idx;
    logic [PtrW-1:0] wr_idx;

    assign rd_idx     = rd_ptr[PtrW-1:0];
    assign wr_idx     = wr_ptr[PtrW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) && (wr_idx == rd_idx);
    assign load_entry = (state == StIdle) && dn_go && !dn_go_q;
    assign accept     = (state == StLoad) && dn_wr && !dn_wr_q;
    assign ack_hit    = mem_req && mem_ack;
    // The head stays in the FIFO until acknowledged, so the ack is the pop.
    assign push       = accept && (!fifo_full || ack_hit);
    assign issue      = !mem_req && !fifo_empty;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_idx] <= dn_addr;
            fifo_data[wr_idx] <= dn_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= StIdle;
            dn_go_q        <= 1'b0;
            dn_wr_q        <= 1'b0;
            exec_latched   <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            cpu_hold       <= 1'b0;
            cpu_start      <= 1'b0;
            cpu_start_addr <= '0;
            dn_overflow    <= 1'b0;
            byte_count     <= '0;
        end else begin
            dn_go_q   <= dn_go;
            dn_wr_q   <= dn_wr;
            cpu_start <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (accept && !push) begin
                dn_overflow <= 1'b1;
            end

            if (issue) begin
                mem_req   <= 1'b1;
                mem_addr  <= BASE_ADDR + MEM_AW'(fifo_addr[rd_idx]);
                mem_wdata <= fifo_data[rd_idx];
            end else if (ack_hit) begin
                mem_req    <= 1'b0;
                rd_ptr     <= rd_ptr + PtrOne;
                byte_count <= byte_count + 17'd1;
            end

            if (execute_enable && ((state == StLoad) || (state == StDrain))) begin
                cpu_start_addr <= execute_addr;
                exec_latched   <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (load_entry) begin
                        state        <= StLoad;
                        cpu_hold     <= 1'b1;
                        byte_count   <= '0;
                        dn_overflow  <= 1'b0;
                        exec_latched <= 1'b0;
                    end
                end
                StLoad: begin
                    if (!dn_go) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (fifo_empty && !mem_req) begin
                        cpu_hold <= 1'b0;
                        if (exec_latched || execute_enable) begin
                            state     <= StLaunch;
                            cpu_start <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                StLaunch: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef DN_SINK_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset || load_entry) begin
            dn_checksum <= '0;
        end else if (ack_hit) begin
            dn_checksum <= dn_checksum + {8'h00, mem_wdata};
        end
    end
`endif

endmodule

// File: tb/tb_dn_ram_sink.sv
// Directed self-checking bench for dn_ram_sink; a negedge RAM responder logs every committed write.
// Build with DN_SINK_CHECKSUM_EN to also check dn_checksum.
module tb_dn_ram_sink;

    localparam logic [20:0] Base = 21'h1FFFF0;

    logic        clk = 1'b0;
    logic        reset;
    logic        dn_go;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [15:0] execute_addr;
    logic        execute_enable;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        cpu_start;
    logic [15:0] cpu_start_addr;
    logic        dn_overflow;
    logic [16:0] byte_count;
`ifdef DN_SINK_CHECKSUM_EN
    logic [15:0] dn_checksum;
`endif

    int passed = 0;
    int total  = 0;

    bit ack_en = 1'b0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int start_bad = 0;
    int ack_cnt = 0;
    int last_ack_cyc = 0;

    logic [20:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [20:0] got_addr[$];
    logic [7:0]  got_data[$];

    dn_ram_sink #(
        .FIFO_DEPTH(4),
        .MEM_AW    (21),
        .BASE_ADDR (Base)
    ) dut (
        .clk_sys       (clk),
        .reset         (reset),
        .dn_go         (dn_go),
        .dn_wr         (dn_wr),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .execute_addr  (execute_addr),
        .execute_enable(execute_enable),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .cpu_start     (cpu_start),
        .cpu_start_addr(cpu_start_addr),
        .dn_overflow   (dn_overflow),
        .byte_count    (byte_count)
`ifdef DN_SINK_CHECKSUM_EN
        ,
        .dn_checksum   (dn_checksum)
`endif
    );

    always #5 clk = ~clk;

    // RAM arbiter model: acks in the first cycle a request is seen, when enabled.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (cpu_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (cpu_hold || mem_req) start_bad++;
        end
        if (reset) begin
            mem_ack = 1'b0;
        end else if (mem_req && !mem_ack && ack_en) begin
            mem_ack = 1'b1;
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            last_ack_cyc = cyc;
            ack_cnt++;
        end else begin
            mem_ack = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit expect_kept);
        dn_addr = a;
        dn_data = d;
        dn_wr   = 1'b1;
        if (expect_kept) begin
            exp_addr.push_back(Base + {5'b0, a});
            exp_data.push_back(d);
        end
        tick();
        dn_wr = 1'b0;
        tick();
    endtask

    task automatic clear_logs();
        exp_addr.delete();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic wait_hold_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!cpu_hold) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (3) tick();
    endtask

    function automatic int log_errors();
        int errs = 0;
        if (got_addr.size() != exp_addr.size()) return 1000000;
        foreach (exp_addr[i]) begin
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) errs++;
        end
        return errs;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_req, cpu_hold, cpu_start, dn_overflow} !== 4'b0000)
            $display("FAIL reset_flags: got %b, want 0000", {mem_req, cpu_hold, cpu_start, dn_overflow});
        else passed++;
        total++;
        if (mem_addr !== 21'h0 || mem_wdata !== 8'h0)
            $display("FAIL reset_port: addr %h data %h, want 0", mem_addr, mem_wdata);
        else passed++;
        total++;
        if (byte_count !== 17'd0 || cpu_start_addr !== 16'h0)
            $display("FAIL reset_counts: count %0d start_addr %h, want 0", byte_count, cpu_start_addr);
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        bit ok;
        int s0;
        clear_logs();
        s0 = start_cnt;
        ack_en = 1'b1;
        dn_go = 1'b1;
        tick();
        tick();
        total++;
        if (cpu_hold !== 1'b1) $display("FAIL stream_hold: got %b, want 1", cpu_hold);
        else passed++;
        for (int i = 0; i < 276; i++) send_byte(16'(i), 8'(i * 37 + 5), 1'b1);
        dn_go = 1'b0;
        wait_hold_low(ok);
        total++;
        if (!ok) $display("FAIL stream_drain_timeout: cpu_hold stuck at %b, want 0", cpu_hold);
        else passed++;
        total++;
        if (log_errors() != 0)
            $display("FAIL stream_writes: %0d writes, %0d bad, want 276 writes 0 bad", got_addr.size(), log_errors());
        else passed++;
        total++;
        if (byte_count !== 17'd276) $display("FAIL stream_count: got %0d, want 276", byte_count);
        else passed++;
        total++;
        if (dn_overflow !== 1'b0) $display("FAIL stream_overflow: got %b, want 0", dn_overflow);
        else passed++;
        total++;
        if (start_cnt != s0) $display("FAIL stream_no_start: got %0d pulses, want 0", start_cnt - s0);
        else passed++;
    endtask

    task automatic test_exec_deferred();
        int s0;
        int a0;
        bit seen;
        clear_logs();
        ack_en = 1'b0;
        s0 = start_cnt;
        a0 = ack_cnt;
        dn_go = 1'b1;
        tick();
        tick();
        execute_addr   = 16'h1234;
        execute_enable = 1'b1;
        tick();
        execute_enable = 1'b0;
        send_byte(16'h0100, 8'hA1, 1'b1);
        send_byte(16'h0101, 8'hA2, 1'b1);
        send_byte(16'h0102, 8'hA3, 1'b1);
        // Latest execute pulse lands in the same cycle dn_go falls.
        dn_go          = 1'b0;
        execute_addr   = 16'h0000;
        execute_enable = 1'b1;
        tick();
        execute_enable = 1'b0;
        repeat (10) tick();
        total++;
        if (start_cnt != s0 || cpu_hold !== 1'b1)
            $display("FAIL exec_early: pulses %0d hold %b, want 0 and 1", start_cnt - s0, cpu_hold);
        else passed++;
        ack_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (start_cnt != s0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!seen) $display("FAIL exec_start_timeout: pulses %0d, want 1", start_cnt - s0);
        else passed++;
        repeat (3) tick();
        total++;
        if (start_cnt - s0 != 1 || ack_cnt - a0 != 3)
            $display("FAIL exec_counts: pulses %0d acks %0d, want 1 and 3", start_cnt - s0, ack_cnt - a0);
        else passed++;
        total++;
        if (start_cyc != last_ack_cyc + 2)
            $display("FAIL exec_timing: start cycle %0d, want %0d", start_cyc, last_ack_cyc + 2);
        else passed++;
        total++;
        if (cpu_start_addr !== 16'h0000 || start_bad != 0)
            $display("FAIL exec_addr_hold: addr %h bad %0d, want 0000 and 0", cpu_start_addr, start_bad);
        else passed++;
        total++;
        if (byte_count !== 17'd3 || log_errors() != 0)
            $display("FAIL exec_writes: count %0d bad %0d, want 3 and 0", byte_count, log_errors());
        else passed++;
    endtask

    task automatic test_overflow();
        bit ok;
        clear_logs();
        ack_en = 1'b0;
        dn_go = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) send_byte(16'h0200 + 16'(i), 8'h50 + 8'(i), 1'b1);
        total++;
        if (dn_overflow !== 1'b0) $display("FAIL ovf_early: got %b, want 0", dn_overflow);
        else passed++;
        send_byte(16'h0204, 8'h54, 1'b0);
        total++;
        if (dn_overflow !== 1'b1) $display("FAIL ovf_set: got %b, want 1", dn_overflow);
        else passed++;
        repeat (30) tick();
        total++;
        if (mem_req !== 1'b1 || mem_wdata !== 8'h50 || mem_addr !== Base + 21'h200)
            $display("FAIL ovf_held_req: req %b addr %h data %h, want 1 %h 50",
                     mem_req, mem_addr, mem_wdata, Base + 21'h200);
        else passed++;
        // Ack and a new byte in the same cycle on a full FIFO: the byte must be kept.
        ack_en = 1'b1;
        send_byte(16'h0205, 8'h55, 1'b1);
        repeat (20) tick();
        total++;
        if (byte_count !== 17'd5) $display("FAIL ovf_pop_push: count %0d, want 5", byte_count);
        else passed++;
        send_byte(16'h0210, 8'h60, 1'b1);
        send_byte(16'h0211, 8'h61, 1'b1);
        dn_go = 1'b0;
        wait_hold_low(ok);
        total++;
        if (!ok || byte_count !== 17'd7)
            $display("FAIL ovf_final_count: ok %b count %0d, want 1 and 7", ok, byte_count);
        else passed++;
        total++;
        if (dn_overflow !== 1'b1 || log_errors() != 0)
            $display("FAIL ovf_sticky_log: ovf %b bad %0d, want 1 and 0", dn_overflow, log_errors());
        else passed++;
    endtask

    task automatic test_checksum();
        bit ok;
        int s0;
        clear_logs();
        ack_en = 1'b1;
        s0 = start_cnt;
        dn_go = 1'b1;
        tick();
        tick();
        total++;
        if (dn_overflow !== 1'b0 || byte_count !== 17'd0)
            $display("FAIL load_entry_clear: ovf %b count %0d, want 0 and 0", dn_overflow, byte_count);
        else passed++;
        // A level held high must count as a single byte.
        dn_addr = 16'h0300;
        dn_data = 8'hFF;
        dn_wr   = 1'b1;
        exp_addr.push_back(Base + 21'h300);
        exp_data.push_back(8'hFF);
        repeat (3) tick();
        dn_wr = 1'b0;
        tick();
        send_byte(16'h0301, 8'h01, 1'b1);
        send_byte(16'h0302, 8'h80, 1'b1);
        dn_go = 1'b0;
        wait_hold_low(ok);
        total++;
        if (!ok || byte_count !== 17'd3 || log_errors() != 0)
            $display("FAIL csum_writes: ok %b count %0d bad %0d, want 1 3 0", ok, byte_count, log_errors());
        else passed++;
        total++;
        if (start_cnt != s0 || cpu_hold !== 1'b0)
            $display("FAIL csum_no_exec: pulses %0d hold %b, want 0 and 0", start_cnt - s0, cpu_hold);
        else passed++;
`ifdef DN_SINK_CHECKSUM_EN
        total++;
        if (dn_checksum !== 16'h0180) $display("FAIL checksum: got %h, want 0180", dn_checksum);
        else passed++;
`endif
    endtask

    task automatic test_wrap_reset();
        bit ok;
        int s0;
        clear_logs();
        ack_en = 1'b0;
        s0 = start_cnt;
        dn_go = 1'b1;
        tick();
        tick();
        execute_addr   = 16'hBEEF;
        execute_enable = 1'b1;
        tick();
        execute_enable = 1'b0;
        send_byte(16'h0020, 8'hC3, 1'b0);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 21'h000010 || mem_wdata !== 8'hC3)
            $display("FAIL wrap_addr: req %b addr %h data %h, want 1 000010 c3", mem_req, mem_addr, mem_wdata);
        else passed++;
        reset = 1'b1;
        dn_go = 1'b0;
        tick();
        total++;
        if ({mem_req, cpu_hold, cpu_start, dn_overflow} !== 4'b0000 || byte_count !== 17'd0)
            $display("FAIL midload_reset_flags: flags %b count %0d, want 0000 0",
                     {mem_req, cpu_hold, cpu_start, dn_overflow}, byte_count);
        else passed++;
        total++;
        if (mem_addr !== 21'h0 || mem_wdata !== 8'h0 || cpu_start_addr !== 16'h0)
            $display("FAIL midload_reset_regs: addr %h data %h start %h, want 0",
                     mem_addr, mem_wdata, cpu_start_addr);
        else passed++;
        reset = 1'b0;
        tick();
        clear_logs();
        ack_en = 1'b1;
        dn_go = 1'b1;
        tick();
        tick();
        total++;
        if (cpu_hold !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL restart_clean: hold %b req %b, want 1 and 0", cpu_hold, mem_req);
        else passed++;
        send_byte(16'h0021, 8'h3C, 1'b1);
        dn_go = 1'b0;
        wait_hold_low(ok);
        total++;
        if (!ok || byte_count !== 17'd1 || log_errors() != 0 || start_cnt != s0)
            $display("FAIL restart_result: ok %b count %0d bad %0d pulses %0d, want 1 1 0 0",
                     ok, byte_count, log_errors(), start_cnt - s0);
        else passed++;
    endtask

    initial begin
        reset          = 1'b1;
        dn_go          = 1'b0;
        dn_wr          = 1'b0;
        dn_addr        = 16'h0;
        dn_data        = 8'h0;
        execute_addr   = 16'h0;
        execute_enable = 1'b0;
        test_reset();
        test_stream();
        test_exec_deferred();
        test_overflow();
        test_checksum();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
